// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory controller.
package dmem_pkg;

    // Access size encodings; 2'b11 is reserved and behaves as a word access.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Controller operating mode: CPU traffic or UART programming session.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PROG = 1'b1
    } state_t;

    // True when the byte offset is not a natural boundary for the access size.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Byte-lane write enables for an aligned access (little-endian).
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001 << off;
            SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Pick the addressed byte/half out of a memory word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] off,
                                                 input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed single-port RAM built from four byte-wide lanes so each
// lane maps onto block RAM with its own write enable; read data is registered.
module dmem_ram #(
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    we_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    localparam int DEPTH = 1 << AW;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            // Byte lane: optional write plus synchronous read of the same address.
            always_ff @(posedge clk_i) begin
                if (we_i[gi]) begin
                    mem[addr_i] <= wdata_i[8*gi +: 8];
                end
                rd_q <= mem[addr_i];
            end

            assign rdata_o[8*gi +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word CPU port with misalignment
// reporting, plus a UART programming mode that owns the RAM port.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int UPG_CNT_W = 12
) (
    input  logic                 ram_clk_i,
    input  logic                 ram_rstn_i,
    input  logic                 ram_req_i,
    input  logic                 ram_wen_i,
    input  logic [1:0]           ram_size_i,
    input  logic                 ram_unsigned_i,
    input  logic [ADDR_W-1:0]    ram_adr_i,
    input  logic [31:0]          ram_dat_i,
    output logic [31:0]          ram_dat_o,
    output logic                 ram_rvalid_o,
    output logic                 ram_misalign_o,
    output logic                 ram_stall_o,
    input  logic                 upg_en_i,
    input  logic                 upg_wen_i,
    input  logic [ADDR_W-3:0]    upg_adr_i,
    input  logic [31:0]          upg_dat_i,
    input  logic                 upg_done_i,
    output logic [UPG_CNT_W-1:0] upg_cnt_o
);

    state_t               state_q, state_d;
    logic [UPG_CNT_W-1:0] upg_cnt_q, upg_cnt_d;
    logic                 rvalid_q, rvalid_d;
    logic                 misalign_q, misalign_d;
    logic [1:0]           off_q, off_d;
    logic [1:0]           size_q, size_d;
    logic                 uns_q, uns_d;

    logic                 cpu_acc;
    logic                 cpu_mis;
    logic [ADDR_W-3:0]    ram_addr;
    logic [3:0]           ram_we;
    logic [31:0]          ram_wdata;
    logic [31:0]          ram_rdata;

    // The CPU is blocked as soon as a session is requested, not one cycle later.
    assign ram_stall_o = (state_q == ST_PROG) || upg_en_i;

    // Mode transitions and the saturating programming word counter.
    always_comb begin
        state_d   = state_q;
        upg_cnt_d = upg_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (upg_en_i) begin
                    state_d   = ST_PROG;
                    upg_cnt_d = '0;
                end
            end
            default: begin
                if (upg_wen_i && (upg_cnt_q != '1)) begin
                    upg_cnt_d = upg_cnt_q + UPG_CNT_W'(1);
                end
                if (upg_done_i) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // RAM port steering and capture of per-access info for the response cycle.
    always_comb begin
        cpu_acc    = ram_req_i && !ram_stall_o;
        cpu_mis    = is_misaligned(ram_size_i, ram_adr_i[1:0]);
        ram_addr   = ram_adr_i[ADDR_W-1:2];
        ram_we     = 4'b0000;
        ram_wdata  = ram_dat_i;
        rvalid_d   = 1'b0;
        misalign_d = 1'b0;
        off_d      = ram_adr_i[1:0];
        size_d     = ram_size_i;
        uns_d      = ram_unsigned_i;

        if (state_q == ST_PROG) begin
            ram_addr  = upg_adr_i;
            ram_we    = upg_wen_i ? 4'b1111 : 4'b0000;
            ram_wdata = upg_dat_i;
        end else begin
            // Replicate right-aligned store data into every lane; enables pick the lane.
            case (ram_size_i)
                SZ_BYTE: ram_wdata = {4{ram_dat_i[7:0]}};
                SZ_HALF: ram_wdata = {2{ram_dat_i[15:0]}};
                default: ram_wdata = ram_dat_i;
            endcase
            if (cpu_acc && ram_wen_i && !cpu_mis) begin
                ram_we = lane_mask(ram_size_i, ram_adr_i[1:0]);
            end
            // Misaligned stores also answer so the CPU can trap on them.
            rvalid_d   = cpu_acc && (!ram_wen_i || cpu_mis);
            misalign_d = cpu_acc && cpu_mis;
        end
    end

    // Controller state and response registers; RAM contents are never reset.
    always_ff @(posedge ram_clk_i or negedge ram_rstn_i) begin
        if (!ram_rstn_i) begin
            state_q    <= ST_RUN;
            upg_cnt_q  <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            off_q      <= 2'b00;
            size_q     <= SZ_WORD;
            uns_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            upg_cnt_q  <= upg_cnt_d;
            rvalid_q   <= rvalid_d;
            misalign_q <= misalign_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
        end
    end

    dmem_ram #(
        .AW (ADDR_W - 2)
    ) u_ram (
        .clk_i   (ram_clk_i),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Load data is built from registered RAM output and registered access info;
    // it is forced to zero outside a good load pulse, which also covers reset.
    assign ram_dat_o      = (rvalid_q && !misalign_q)
                          ? load_extract(ram_rdata, off_q, size_q, uns_q) : 32'h0;
    assign ram_rvalid_o   = rvalid_q;
    assign ram_misalign_o = misalign_q;
    assign upg_cnt_o      = upg_cnt_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares data, misalign flag and latency.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int ADDR_W    = 14;
    localparam int UPG_CNT_W = 12;

    logic                 clk;
    logic                 rst_n;
    logic                 req, wen, uns;
    logic [1:0]           size;
    logic [ADDR_W-1:0]    adr;
    logic [31:0]          dat_in;
    logic [31:0]          dat_out;
    logic                 rvalid, misalign, stall;
    logic                 upg_en, upg_wen, upg_done;
    logic [ADDR_W-3:0]    upg_adr;
    logic [31:0]          upg_dat;
    logic [UPG_CNT_W-1:0] upg_cnt;

    dmem_ctrl #(
        .ADDR_W    (ADDR_W),
        .UPG_CNT_W (UPG_CNT_W)
    ) dut (
        .ram_clk_i      (clk),
        .ram_rstn_i     (rst_n),
        .ram_req_i      (req),
        .ram_wen_i      (wen),
        .ram_size_i     (size),
        .ram_unsigned_i (uns),
        .ram_adr_i      (adr),
        .ram_dat_i      (dat_in),
        .ram_dat_o      (dat_out),
        .ram_rvalid_o   (rvalid),
        .ram_misalign_o (misalign),
        .ram_stall_o    (stall),
        .upg_en_i       (upg_en),
        .upg_wen_i      (upg_wen),
        .upg_adr_i      (upg_adr),
        .upg_dat_i      (upg_dat),
        .upg_done_i     (upg_done),
        .upg_cnt_o      (upg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dat;
        logic        mis;
        logic [31:0] ecyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("check %s ok: 0x%08h", name, act);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation, in the right cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rvalid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid: got dat=0x%08h mis=%0b at cycle %0d, expected no response",
                             dat_out, misalign, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (dat_out !== e.dat || misalign !== e.mis || cyc != int'(e.ecyc)) begin
                        errors++;
                        $display("FAIL response: got dat=0x%08h mis=%0b cyc=%0d, expected dat=0x%08h mis=%0b cyc=%0d",
                                 dat_out, misalign, cyc, e.dat, e.mis, e.ecyc);
                    end else begin
                        $display("rsp ok: dat=0x%08h mis=%0b cyc=%0d", dat_out, misalign, cyc);
                    end
                end
            end
        end
    end

    // Present one CPU request for one edge; optionally record the expected response.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic resp, input logic [31:0] edat, input logic emis);
        req    = 1'b1;
        wen    = w;
        size   = sz;
        uns    = u;
        adr    = a;
        dat_in = d;
        if (resp) sb_q.push_back(exp_t'{dat: edat, mis: emis, ecyc: 32'(cyc + 1)});
        $display("req %s sz=%0d uns=%0b adr=0x%04h dat=0x%08h resp=%0b", w ? "ST" : "LD", sz, u, a, d, resp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0;
        wen = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; req = 1'b0; wen = 1'b0; uns = 1'b0; size = SZ_WORD;
        adr = '0; dat_in = '0; upg_en = 1'b0; upg_wen = 1'b0; upg_done = 1'b0;
        upg_adr = '0; upg_dat = '0;
        #1 rst_n = 1'b0;
        #1;
        check32("rst_rvalid",   32'(rvalid),   32'h0);
        check32("rst_misalign", 32'(misalign), 32'h0);
        check32("rst_dat",      dat_out,       32'h0);
        check32("rst_cnt",      32'(upg_cnt),  32'h0);
        check32("rst_stall",    32'(stall),    32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word store/load, byte sub-word and sign handling
        issue(1, SZ_WORD, 0, 14'h0010, 32'hDEADBEEF, 0, 32'h0, 0);
        issue(0, SZ_WORD, 0, 14'h0010, 32'h0,        1, 32'hDEADBEEF, 0);
        issue(1, SZ_BYTE, 0, 14'h0013, 32'hFFFFFF80, 0, 32'h0, 0);
        issue(0, SZ_BYTE, 0, 14'h0013, 32'h0,        1, 32'hFFFFFF80, 0);
        issue(0, SZ_BYTE, 1, 14'h0013, 32'h0,        1, 32'h00000080, 0);
        issue(0, SZ_WORD, 0, 14'h0010, 32'h0,        1, 32'h80ADBEEF, 0);
        issue(0, SZ_WORD, 1, 14'h0010, 32'h0,        1, 32'h80ADBEEF, 0);
        issue(0, SZ_BYTE, 1, 14'h0011, 32'h0,        1, 32'h000000BE, 0);
        issue(0, SZ_BYTE, 0, 14'h0011, 32'h0,        1, 32'hFFFFFFBE, 0);
        // Half lanes, upper store bits ignored, reserved size as word
        issue(1, SZ_HALF, 0, 14'h0016, 32'hAAAA1234, 0, 32'h0, 0);
        issue(1, SZ_HALF, 0, 14'h0014, 32'h5555BEEF, 0, 32'h0, 0);
        issue(0, SZ_HALF, 0, 14'h0016, 32'h0,        1, 32'h00001234, 0);
        issue(0, SZ_HALF, 0, 14'h0014, 32'h0,        1, 32'hFFFFBEEF, 0);
        issue(0, SZ_HALF, 1, 14'h0014, 32'h0,        1, 32'h0000BEEF, 0);
        issue(0, 2'b11,   0, 14'h0014, 32'h0,        1, 32'h1234BEEF, 0);
        // Misaligned accesses: pulse with flag, zero data, no write
        issue(0, SZ_HALF, 0, 14'h0011, 32'h0,        1, 32'h0, 1);
        issue(0, SZ_WORD, 0, 14'h0011, 32'h0,        1, 32'h0, 1);
        issue(1, SZ_WORD, 0, 14'h0012, 32'hFFFFFFFF, 1, 32'h0, 1);
        issue(1, SZ_HALF, 0, 14'h0013, 32'h00000000, 1, 32'h0, 1);
        issue(0, SZ_WORD, 0, 14'h0010, 32'h0,        1, 32'h80ADBEEF, 0);
        issue(1, SZ_WORD, 0, 14'h000C, 32'h12345678, 0, 32'h0, 0);

        // Load accepted just before the session starts must still answer
        issue(0, SZ_WORD, 0, 14'h0010, 32'h0,        1, 32'h80ADBEEF, 0);
        req = 1'b0;
        upg_en = 1'b1;
        #1;
        check32("stall_on_en", 32'(stall), 32'h1);
        @(posedge clk);
        #1;
        check32("cnt_entry1", 32'(upg_cnt), 32'h0);
        // CPU traffic during PROG is ignored
        issue(1, SZ_WORD, 0, 14'h000C, 32'hFFFFFFFF, 0, 32'h0, 0);
        check32("stall_prog", 32'(stall), 32'h1);
        issue(0, SZ_WORD, 0, 14'h0010, 32'h0,        0, 32'h0, 0);
        req = 1'b0;
        upg_wen = 1'b1; upg_adr = 12'd0; upg_dat = 32'h11;
        @(posedge clk); #1;
        upg_adr = 12'd1; upg_dat = 32'h22;
        @(posedge clk); #1;
        check32("cnt_two", 32'(upg_cnt), 32'h2);
        // Last write together with done: written, then back to RUN
        upg_adr = 12'd2; upg_dat = 32'h33; upg_done = 1'b1; upg_en = 1'b0;
        @(posedge clk); #1;
        upg_wen = 1'b0; upg_done = 1'b0;
        check32("cnt_three", 32'(upg_cnt), 32'h3);
        check32("stall_run", 32'(stall), 32'h0);
        // Programming writes outside a session are ignored and the count holds
        upg_wen = 1'b1; upg_adr = 12'd1; upg_dat = 32'hBAD;
        @(posedge clk); #1;
        upg_wen = 1'b0;
        check32("cnt_hold", 32'(upg_cnt), 32'h3);
        issue(0, SZ_WORD, 0, 14'h0000, 32'h0, 1, 32'h00000011, 0);
        issue(0, SZ_WORD, 0, 14'h0004, 32'h0, 1, 32'h00000022, 0);
        issue(0, SZ_WORD, 0, 14'h0008, 32'h0, 1, 32'h00000033, 0);
        issue(0, SZ_WORD, 0, 14'h000C, 32'h0, 1, 32'h12345678, 0);
        idle();

        // Second session cut short by reset
        upg_en = 1'b1;
        @(posedge clk); #1;
        check32("cnt_entry2", 32'(upg_cnt), 32'h0);
        upg_wen = 1'b1; upg_adr = 12'd0; upg_dat = 32'h55;
        @(posedge clk); #1;
        upg_wen = 1'b0;
        check32("cnt_one", 32'(upg_cnt), 32'h1);
        #2;
        rst_n = 1'b0; upg_en = 1'b0;
        #1;
        check32("arst_cnt",    32'(upg_cnt),  32'h0);
        check32("arst_stall",  32'(stall),    32'h0);
        check32("arst_rvalid", 32'(rvalid),   32'h0);
        check32("arst_dat",    dat_out,       32'h0);
        check32("arst_mis",    32'(misalign), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue(0, SZ_WORD, 0, 14'h0000, 32'h0, 1, 32'h00000055, 0);
        issue(0, SZ_WORD, 0, 14'h0004, 32'h0, 1, 32'h00000022, 0);
        idle();

        repeat (4) @(posedge clk);
        #1;
        check32("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
